// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// read-latency bounds and default bus geometry.
package data_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 4;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;

  // Keeps an out-of-range READ_LATENCY from producing a zero-width pipeline.
  function automatic int clamp_latency(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/data_memory_responder_memory_array.sv
// Single-port synchronous RAM, read-first, one cycle of read latency.
module memory_array #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // NOTE: the array has no reset so it maps onto block RAM; its contents
  // are initialised by the clear sequencer in the parent instead.
  // NOTE: non-blocking assignments here give read-first semantics: rdata_o
  // samples the old word even when the same edge writes it.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: clears the array after reset, then serves 16-bit
// word reads/writes with a fixed, parameterised read latency.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_done
);

  localparam int                    LAT         = clamp_latency(READ_LATENCY);
  localparam state_e                RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    bus_rd, bus_wr;
  logic                    ram_en, ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata, pipe_out;
  logic [LAT-1:0]          vld_q;
  logic [LAT:0]            vld_chain;
  logic [DATA_WIDTH-1:0]   data_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) state_d = READY;
        else                        clr_cnt_d = clr_cnt_q + 1'b1;
      end
      READY: ;
      default: state_d = RESET_STATE;
    endcase
  end

  assign bus_rd    = (state_q == READY) && mem_enable && read_enable;
  assign bus_wr    = (state_q == READY) && mem_enable && write_enable;
  assign init_done = (state_q == READY);

  // While clearing, the sequencer owns the RAM port and bus traffic is dropped.
  always_comb begin
    ram_en    = bus_rd || bus_wr;
    ram_we    = bus_wr;
    ram_addr  = address;
    ram_wdata = data_in;
    if (state_q == CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
    end
  end

  memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign vld_chain = {vld_q, bus_rd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_chain[LAT-1:0];
  end

  // Data stages carry no reset: validity travels in vld_q alongside them.
  if (LAT > 1) begin : g_pipe
    logic [DATA_WIDTH-1:0] stage_q [1:LAT-1];
    always_ff @(posedge clk) begin
      stage_q[1] <= ram_rdata;
      for (int i = 2; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
    assign pipe_out = stage_q[LAT-1];
  end else begin : g_no_pipe
    assign pipe_out = ram_rdata;
  end

  assign rd_valid = vld_q[LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         data_out_q <= '0;
    else if (rd_valid) data_out_q <= pipe_out;
  end

  assign data_out = rd_valid ? pipe_out : data_out_q;

endmodule
